// File: rtl/fabric_forward_scheduler.sv
// Round-robin frame scheduler: grants one ingress port, re-emits its 128-bit beat stream tagged with source/start/last/abort.
// Latency: out_* registered, 1 cycle after each accepted beat; grant pulse 1 cycle after the IDLE decision.
// Backpressure: none; upstream beats are always accepted, beats outside a granted frame are dropped and counted.
module fabric_forward_scheduler #(
    parameter int NUM_PORTS      = 15,
    parameter int PORT_BITS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_ram_ctl,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] port_frame_ready,
    output logic [NUM_PORTS-1:0] forward_en,
    input  logic                 frame_valid,
    input  logic                 frame_last,
    input  logic [127:0]         frame_data,
    output logic                 out_valid,
    output logic                 out_start,
    output logic                 out_last,
    output logic                 out_abort,
    output logic [PORT_BITS-1:0] out_src_port,
    output logic [127:0]         out_data,
    output logic [31:0]          frame_count,
    output logic [31:0]          timeout_count,
    output logic [31:0]          stray_count
);

    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, GAP} state_t;

    localparam int             TW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   fwd_q, fwd_d;
    logic [PORT_BITS-1:0]   cur_port_q, cur_port_d;
    logic [PORT_BITS-1:0]   last_grant_q, last_grant_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_start_q, out_start_d;
    logic                   out_last_q, out_last_d;
    logic                   out_abort_q, out_abort_d;
    logic [PORT_BITS-1:0]   out_src_q, out_src_d;
    logic [127:0]           out_data_q, out_data_d;
    logic [31:0]            frame_cnt_q, frame_cnt_d;
    logic [31:0]            tmo_cnt_q, tmo_cnt_d;
    logic [31:0]            stray_cnt_q, stray_cnt_d;

    logic                   found;
    logic [PORT_BITS-1:0]   sel;
    int                     scan_idx;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Scan starts just after the previous winner and wraps at NUM_PORTS, not at 2^PORT_BITS.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            scan_idx = int'(last_grant_q) + i;
            if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
            if (!found && port_frame_ready[PORT_BITS'(scan_idx)]) begin
                found = 1'b1;
                sel   = PORT_BITS'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fwd_d        = '0;
        cur_port_d   = cur_port_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        out_valid_d  = 1'b0;
        out_start_d  = 1'b0;
        out_last_d   = 1'b0;
        out_abort_d  = 1'b0;
        out_src_d    = out_src_q;
        out_data_d   = out_data_q;
        frame_cnt_d  = frame_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        stray_cnt_d  = stray_cnt_q;

        case (state_q)
            IDLE: begin
                if (frame_valid) stray_cnt_d = sat_inc(stray_cnt_q);
                if (found) begin
                    fwd_d[sel]   = 1'b1;
                    cur_port_d   = sel;
                    last_grant_d = sel;
                    timer_d      = '0;
                    state_d      = WAIT;
                end
            end
            WAIT, ACTIVE: begin
                if (frame_valid) begin
                    out_valid_d = 1'b1;
                    out_start_d = (state_q == WAIT);
                    out_last_d  = frame_last;
                    out_src_d   = cur_port_q;
                    out_data_d  = frame_data;
                    timer_d     = '0;
                    if (frame_last) begin
                        frame_cnt_d = sat_inc(frame_cnt_q);
                        state_d     = GAP;
                    end else begin
                        state_d     = ACTIVE;
                    end
                end else if (timer_q == TMAX) begin
                    tmo_cnt_d = sat_inc(tmo_cnt_q);
                    state_d   = GAP;
                    // A started frame must be closed downstream; a silent grant emits nothing.
                    if (state_q == ACTIVE) begin
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        out_abort_d = 1'b1;
                        out_src_d   = cur_port_q;
                        out_data_d  = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (frame_valid) stray_cnt_d = sat_inc(stray_cnt_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ram_ctl) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fwd_q        <= '0;
            cur_port_q   <= '0;
            last_grant_q <= PORT_BITS'(NUM_PORTS - 1);
            timer_q      <= '0;
            out_valid_q  <= 1'b0;
            out_start_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_abort_q  <= 1'b0;
            out_src_q    <= '0;
            out_data_q   <= '0;
            frame_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            stray_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fwd_q        <= fwd_d;
            cur_port_q   <= cur_port_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            out_valid_q  <= out_valid_d;
            out_start_q  <= out_start_d;
            out_last_q   <= out_last_d;
            out_abort_q  <= out_abort_d;
            out_src_q    <= out_src_d;
            out_data_q   <= out_data_d;
            frame_cnt_q  <= frame_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            stray_cnt_q  <= stray_cnt_d;
        end
    end

    assign forward_en    = fwd_q;
    assign out_valid     = out_valid_q;
    assign out_start     = out_start_q;
    assign out_last      = out_last_q;
    assign out_abort     = out_abort_q;
    assign out_src_port  = out_src_q;
    assign out_data      = out_data_q;
    assign frame_count   = frame_cnt_q;
    assign timeout_count = tmo_cnt_q;
    assign stray_count   = stray_cnt_q;

endmodule

// File: tb/tb_fabric_forward_scheduler.sv
// Directed bench for fabric_forward_scheduler: stimulus pushes expected grants/beats, negedge monitors pop and compare.
module tb_fabric_forward_scheduler;

    localparam int NP = 15;
    localparam int PB = 4;

    typedef struct packed {
        logic          start;
        logic          last;
        logic          abort;
        logic [PB-1:0] src;
        logic [127:0]  data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] port_frame_ready;
    logic [NP-1:0] forward_en;
    logic          frame_valid;
    logic          frame_last;
    logic [127:0]  frame_data;
    logic          out_valid, out_start, out_last, out_abort;
    logic [PB-1:0] out_src_port;
    logic [127:0]  out_data;
    logic [31:0]   frame_count, timeout_count, stray_count;

    int tests = 0;
    int fails = 0;

    beat_t beat_q[$];
    int    grant_q[$];

    fabric_forward_scheduler #(.NUM_PORTS(NP), .PORT_BITS(PB), .TIMEOUT_CYCLES(1024)) dut (
        .clk_ram_ctl     (clk),
        .rst_n           (rst_n),
        .port_frame_ready(port_frame_ready),
        .forward_en      (forward_en),
        .frame_valid     (frame_valid),
        .frame_last      (frame_last),
        .frame_data      (frame_data),
        .out_valid       (out_valid),
        .out_start       (out_start),
        .out_last        (out_last),
        .out_abort       (out_abort),
        .out_src_port    (out_src_port),
        .out_data        (out_data),
        .frame_count     (frame_count),
        .timeout_count   (timeout_count),
        .stray_count     (stray_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    // Beat monitor
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            beat_t act, exp;
            act = '{out_start, out_last, out_abort, out_src_port, out_data};
            tests++;
            if (beat_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got start=%0b last=%0b abort=%0b src=%0d data=%h, expected no beat",
                         out_start, out_last, out_abort, out_src_port, out_data);
            end else begin
                exp = beat_q.pop_front();
                if (act !== exp) begin
                    fails++;
                    $display("FAIL beat: got start=%0b last=%0b abort=%0b src=%0d data=%h, expected start=%0b last=%0b abort=%0b src=%0d data=%h",
                             act.start, act.last, act.abort, act.src, act.data,
                             exp.start, exp.last, exp.abort, exp.src, exp.data);
                end
            end
        end
    end

    // Grant monitor: every cycle with forward_en set must match exactly one expected grant
    always @(negedge clk) begin
        if ((|forward_en) === 1'b1) begin
            logic [NP-1:0] expv;
            int            p;
            tests++;
            if (grant_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_grant: got forward_en=%h, expected none", forward_en);
            end else begin
                p = grant_q.pop_front();
                expv = '0;
                expv[p] = 1'b1;
                if (forward_en !== expv) begin
                    fails++;
                    $display("FAIL grant: got forward_en=%h, expected %h (port %0d)", forward_en, expv, p);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_valid = 1'b0;
        frame_last = 1'b0;
        frame_data = '0;
        port_frame_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"}, {123'b0, out_valid, out_start, out_last, out_abort, 1'b0}, 128'd0);
        check({tag, "_src_data"}, out_data | {124'b0, out_src_port}, 128'd0);
        check({tag, "_fwd"}, {113'b0, forward_en}, 128'd0);
        check({tag, "_counters"}, {32'b0, frame_count, timeout_count, stray_count}, 128'd0);
    endtask

    task automatic wait_grant(input string name);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (forward_en != '0) seen = 1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: got no grant within 50 cycles, expected a grant", name);
        end
    endtask

    task automatic send_frame(input int n, input int src, input logic [95:0] tag, input bit with_last);
        for (int b = 0; b < n; b++) begin
            frame_valid = 1'b1;
            frame_last  = with_last && (b == n - 1);
            frame_data  = {tag, 32'(b)};
            beat_q.push_back('{(b == 0), frame_last, 1'b0, PB'(src), frame_data});
            @(negedge clk);
        end
        frame_valid = 1'b0;
        frame_last  = 1'b0;
    endtask

    task automatic wait_timeout(input string name, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 1100 && cycles < 0; i++) begin
            @(negedge clk);
            if (timeout_count == 32'd1) cycles = i;
        end
        if (cycles < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got no timeout within 1100 cycles, expected timeout_count=1", name);
        end
    endtask

    initial begin
        int cyc;

        // Reset state
        do_reset();
        @(negedge clk);
        check_idle_outputs("reset");

        // 1: single 4-beat frame from port 0
        port_frame_ready = 15'h0001;
        grant_q.push_back(0);
        wait_grant("t1_grant");
        port_frame_ready = '0;
        send_frame(4, 0, 96'hA1, 1);
        repeat (3) @(negedge clk);
        check("t1_frame_count", 128'(frame_count), 128'd1);
        check("t1_queue_drained", 128'(beat_q.size()), 128'd0);

        // 2: round-robin across all ports, wrap back to port 0
        do_reset();
        port_frame_ready = 15'h7FFF;
        for (int g = 0; g < 16; g++) begin
            grant_q.push_back(g % NP);
            wait_grant("t2_grant");
            send_frame(1, g % NP, 96'hB000 + 96'(g), 1);
            if (g == 15) port_frame_ready = '0;
        end
        repeat (3) @(negedge clk);
        check("t2_frame_count", 128'(frame_count), 128'd16);
        check("t2_grants_drained", 128'(grant_q.size()), 128'd0);

        // 3: grant to port 3 never answered, then next grant continues after port 3
        do_reset();
        port_frame_ready = 15'h0008;
        grant_q.push_back(3);
        wait_grant("t3_grant");
        port_frame_ready = '0;
        wait_timeout("t3_timeout", cyc);
        tests++;
        if (cyc < 1024 || cyc > 1025) begin
            fails++;
            $display("FAIL t3_timeout_latency: got %0d cycles, expected 1024..1025", cyc);
        end
        check("t3_timeout_count", 128'(timeout_count), 128'd1);
        repeat (3) @(negedge clk);
        port_frame_ready = 15'h0019;
        grant_q.push_back(4);
        wait_grant("t3_next_grant");
        port_frame_ready = '0;
        send_frame(1, 4, 96'hC3, 1);
        repeat (3) @(negedge clk);
        check("t3_frame_count", 128'(frame_count), 128'd1);
        check("t3_timeout_final", 128'(timeout_count), 128'd1);

        // 4: port 5 frame stalls after 2nd beat, watchdog closes it with an abort beat
        do_reset();
        port_frame_ready = 15'h0020;
        grant_q.push_back(5);
        wait_grant("t4_grant");
        port_frame_ready = '0;
        send_frame(2, 5, 96'hD5, 0);
        beat_q.push_back('{1'b0, 1'b1, 1'b1, PB'(5), 128'd0});
        wait_timeout("t4_timeout", cyc);
        repeat (3) @(negedge clk);
        check("t4_frame_count", 128'(frame_count), 128'd0);
        check("t4_timeout_count", 128'(timeout_count), 128'd1);
        check("t4_queue_drained", 128'(beat_q.size()), 128'd0);

        // 5: stray beats in IDLE and in GAP
        do_reset();
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        port_frame_ready = 15'h0001;
        grant_q.push_back(0);
        wait_grant("t5_grant");
        port_frame_ready = '0;
        send_frame(1, 0, 96'hE0, 1);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_stray_count", 128'(stray_count), 128'd2);
        check("t5_frame_count", 128'(frame_count), 128'd1);

        // 6: reset asserted during beat 2 of 6
        do_reset();
        port_frame_ready = 15'h0001;
        grant_q.push_back(0);
        wait_grant("t6_grant");
        port_frame_ready = '0;
        send_frame(1, 0, 96'hF0, 0);
        rst_n = 1'b0;
        frame_valid = 1'b1;
        frame_data = {96'hF0, 32'd1};
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_idle_outputs("t6");

        check("end_beats_drained", 128'(beat_q.size()), 128'd0);
        check("end_grants_drained", 128'(grant_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
